// File: rtl/th_ctrl_pkg.sv
// Shared types and helpers for the per-pixel threshold scan controller.
package th_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_COUNT  = 3'd3,
      ST_EVAL   = 3'd4,
      ST_DONE   = 3'd5
   } scan_state_t;

   function automatic logic [31:0] min_u(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

   // Callers keep operand widths well below 31 bits, so the 32-bit sum cannot wrap.
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned width);
      logic [31:0] lim;
      lim = (32'd1 << width) - 32'd1;
      return min_u(a + b, lim);
   endfunction

endpackage

// File: rtl/th_win_counter.sv
// Discriminator edge counter over a fixed window of enabled cycles.
module th_win_counter
#(
   parameter int ACC_W    = 16,
   parameter int WIN_LOG2 = 10
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             count_en,
   input  logic             pulse,
   output logic [ACC_W-1:0] acc,
   output logic             window_done
);

   logic                pul_q;
   logic [WIN_LOG2-1:0] win_cnt;
   logic                pul_rise;

   assign pul_rise    = pulse & ~pul_q;
   assign window_done = count_en && (win_cnt == '1);

   // The edge flop runs every cycle, so an edge during a disabled cycle is consumed and lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pul_q   <= 1'b0;
         acc     <= '0;
         win_cnt <= '0;
      end else begin
         pul_q <= pulse;
         if (clear) begin
            acc     <= '0;
            win_cnt <= '0;
         end else if (count_en) begin
            win_cnt <= win_cnt + 1'b1;
            if (pul_rise && (acc != '1))
               acc <= acc + 1'b1;
         end
      end
   end

endmodule

// File: rtl/th_ctrl_scan.sv
// Threshold controller: scans DAC codes, finds baseline and noise width, drives TH.
module th_ctrl_scan
   import th_ctrl_pkg::*;
#(
   parameter int DAC_W      = 10,
   parameter int OFS_W      = 6,
   parameter int ACC_W      = 16,
   parameter int NW_W       = 4,
   parameter int WIN_LOG2   = 10,
   parameter int SETTLE_CYC = 4,
   parameter int STEP_W     = 3
)
(
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              CLKEn,
   input  logic              DiscriPul,
   input  logic              Bypass,
   input  logic              ScanStart,
   input  logic [DAC_W-1:0]  ScanLo,
   input  logic [DAC_W-1:0]  ScanHi,
   input  logic [STEP_W-1:0] Step,
   input  logic [DAC_W-1:0]  DAC,
   input  logic [OFS_W-1:0]  TH_offset,
   output logic [DAC_W-1:0]  TH,
   output logic [DAC_W-1:0]  BL,
   output logic [NW_W-1:0]   NW,
   output logic [ACC_W-1:0]  Acc,
   output logic [2:0]        StateOut,
   output logic              ScanDone
);

   localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   scan_state_t         state, state_next;
   logic                start_q, start_rise;
   logic [DAC_W-1:0]    hi, code, best_code, best_code_n, bl, th;
   logic [STEP_W-1:0]   step;
   logic [ACC_W-1:0]    best_cnt, acc;
   logic [NW_W-1:0]     nz, nz_inc, nw;
   logic                scan_done;
   logic [SET_W-1:0]    settle_cnt;
   logic                settle_last, count_en, acc_clear, window_done;
   logic                better, last_code, in_scan;
   logic [DAC_W:0]      next_code;

   assign start_rise  = ScanStart & ~start_q;
   assign settle_last = (SETTLE_CYC == 0) || (settle_cnt == SET_W'(SETTLE_CYC - 1));
   assign count_en    = !Bypass && CLKEn && (state == ST_COUNT);
   assign acc_clear   = !Bypass && CLKEn && ((state == ST_INIT) || (state == ST_SETTLE));
   assign next_code   = {1'b0, code} + (DAC_W+1)'(step);
   assign last_code   = next_code > {1'b0, hi};
   assign better      = acc > best_cnt;
   assign best_code_n = better ? code : best_code;
   assign nz_inc      = ((acc != '0) && (nz != '1)) ? nz + 1'b1 : nz;
   assign in_scan     = state inside {ST_INIT, ST_SETTLE, ST_COUNT, ST_EVAL};

   th_win_counter #(
      .ACC_W    (ACC_W),
      .WIN_LOG2 (WIN_LOG2)
   ) u_win (
      .clk         (CLK),
      .rst_n       (RSTn),
      .clear       (acc_clear),
      .count_en    (count_en),
      .pulse       (DiscriPul),
      .acc         (acc),
      .window_done (window_done)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Bypass overrides everything, even on disabled cycles.
   always_comb begin
      state_next = state;
      if (Bypass) begin
         state_next = ST_IDLE;
      end else if (CLKEn) begin
         case (state)
            ST_IDLE, ST_DONE: if (start_rise)   state_next = ST_INIT;
            ST_INIT:                            state_next = ST_SETTLE;
            ST_SETTLE:        if (settle_last)  state_next = ST_COUNT;
            ST_COUNT:         if (window_done)  state_next = ST_EVAL;
            ST_EVAL:          state_next = last_code ? ST_DONE : ST_SETTLE;
            default:                            state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         start_q    <= 1'b0;
         hi         <= '0;
         step       <= '0;
         code       <= '0;
         best_cnt   <= '0;
         best_code  <= '0;
         nz         <= '0;
         bl         <= '0;
         nw         <= '0;
         th         <= '0;
         scan_done  <= 1'b0;
         settle_cnt <= '0;
      end else begin
         if (CLKEn)
            start_q <= ScanStart;

         if (Bypass)
            th <= DAC;
         else if (in_scan)
            th <= code;
         else
            th <= DAC_W'(sat_add(32'(bl), 32'(TH_offset), DAC_W));

         if (Bypass) begin
            scan_done <= 1'b0;
         end else if (CLKEn) begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (start_rise)
                     scan_done <= 1'b0;
               end
               // Lo > Hi collapses to a single-point scan at Lo.
               ST_INIT: begin
                  hi         <= (ScanLo > ScanHi) ? ScanLo : ScanHi;
                  step       <= (Step == '0) ? STEP_W'(1) : Step;
                  code       <= ScanLo;
                  best_cnt   <= '0;
                  best_code  <= ScanLo;
                  nz         <= '0;
                  settle_cnt <= '0;
               end
               ST_SETTLE: begin
                  settle_cnt <= settle_last ? '0 : settle_cnt + 1'b1;
               end
               ST_EVAL: begin
                  if (better)
                     best_cnt <= acc;
                  best_code <= best_code_n;
                  nz        <= nz_inc;
                  if (last_code) begin
                     bl        <= best_code_n;
                     nw        <= nz_inc;
                     scan_done <= 1'b1;
                  end else begin
                     code <= next_code[DAC_W-1:0];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign TH       = th;
   assign BL       = bl;
   assign NW       = nw;
   assign Acc      = acc;
   assign StateOut = state;
   assign ScanDone = scan_done;

endmodule
